// File: rtl/smc_bus_pkg.sv
// Shared types and constants for the static-memory-controller bus master.
//   ADDR_W / DATA_W : bus address and data widths
//   CNT_W           : width of the phase down-counter
//   DEF_*_CYC       : default setup / strobe-pulse / hold lengths in clocks
//   smc_state_t     : transaction phase encoding
package smc_bus_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned DEF_SETUP_CYC = 1;
    localparam int unsigned DEF_PULSE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } smc_state_t;

endpackage

// File: rtl/smc_bus_master.sv
// Single-beat 16-bit bus master for an asynchronous static memory.
// A request accepted in IDLE runs SETUP (CS + address), PULSE (RD or WR
// strobe low) and HOLD (strobes high, CS low) phases, then returns to IDLE
// with a one-cycle rsp_valid_o. All bus pins come straight from flops;
// the data-bus IOBUF lives outside this module.
// Ports:
//   clk_i, reset_i (async, active-low)
//   req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i : request
//   rsp_valid_o/rsp_rdata_o                                  : completion
//   addr_o, data_o, data_i, data_oe_o, cs_n_o, rd_n_o, wr_n_o : memory bus
module smc_bus_master
    import smc_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              data_oe_o,
    output logic              cs_n_o,
    output logic              rd_n_o,
    output logic              wr_n_o
);

    // Counter holds remaining cycles minus one, so a phase ends at zero.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

    smc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic             accept;
    logic             last_pulse;
    logic             last_hold;

    // 16-bit transfers: the byte-select bit is deliberately dropped.
    logic unused_addr_lsb;
    assign unused_addr_lsb = req_addr_i[0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        accept     = 1'b0;
        last_pulse = (state_q == ST_PULSE) && (cnt_q == '0);
        last_hold  = (state_q == ST_HOLD)  && (cnt_q == '0);

        unique case (state_q)
            ST_IDLE: begin
                // req_ready_o is low for the first cycle after reset release.
                if (req_valid_i && req_ready_o) begin
                    accept  = 1'b1;
                    write_d = req_write_i;
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next-state values so each pin
    // changes exactly at the phase boundary with no decode glitches.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            addr_o      <= '0;
            data_o      <= '0;
            data_oe_o   <= 1'b0;
            cs_n_o      <= 1'b1;
            rd_n_o      <= 1'b1;
            wr_n_o      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            req_ready_o <= (state_d == ST_IDLE);
            rsp_valid_o <= last_hold;
            cs_n_o      <= (state_d == ST_IDLE);
            rd_n_o      <= !((state_d == ST_PULSE) && !write_d);
            wr_n_o      <= !((state_d == ST_PULSE) && write_d);
            data_oe_o   <= (state_d != ST_IDLE) && write_d;
            if (accept) begin
                addr_o <= {req_addr_i[ADDR_W-1:1], 1'b0};
                data_o <= req_wdata_i;
            end
            if (last_pulse && !write_q) begin
                rsp_rdata_o <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_smc_bus_master.sv
module tb_smc_bus_master;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Instance A: default timing (1/2/1)
    logic        a_req_valid, a_req_ready, a_req_write;
    logic [24:0] a_req_addr, a_addr;
    logic [15:0] a_req_wdata, a_rsp_rdata, a_data_o, a_data_i, a_model;
    logic        a_rsp_valid, a_oe, a_cs_n, a_rd_n, a_wr_n;
    logic [5:0]  a_ctrl;

    // Instance B: timing 3/5/2
    logic        b_req_valid, b_req_ready, b_req_write;
    logic [24:0] b_req_addr, b_addr;
    logic [15:0] b_req_wdata, b_rsp_rdata, b_data_o, b_data_i, b_model;
    logic        b_rsp_valid, b_oe, b_cs_n, b_rd_n, b_wr_n;
    logic [5:0]  b_ctrl;

    // Memory model: drives its data only while the read strobe is low.
    assign a_data_i = a_rd_n ? 16'h0000 : a_model;
    assign b_data_i = b_rd_n ? 16'h0000 : b_model;

    // {cs_n, rd_n, wr_n, data_oe, rsp_valid, req_ready}
    assign a_ctrl = {a_cs_n, a_rd_n, a_wr_n, a_oe, a_rsp_valid, a_req_ready};
    assign b_ctrl = {b_cs_n, b_rd_n, b_wr_n, b_oe, b_rsp_valid, b_req_ready};

    smc_bus_master dut_a (
        .clk_i(clk), .reset_i(reset_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_write_i(a_req_write), .req_addr_i(a_req_addr),
        .req_wdata_i(a_req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata),
        .addr_o(a_addr), .data_o(a_data_o), .data_i(a_data_i),
        .data_oe_o(a_oe), .cs_n_o(a_cs_n), .rd_n_o(a_rd_n), .wr_n_o(a_wr_n)
    );

    smc_bus_master #(.SETUP_CYC(3), .PULSE_CYC(5), .HOLD_CYC(2)) dut_b (
        .clk_i(clk), .reset_i(reset_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_write_i(b_req_write), .req_addr_i(b_req_addr),
        .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
        .addr_o(b_addr), .data_o(b_data_o), .data_i(b_data_i),
        .data_oe_o(b_oe), .cs_n_o(b_cs_n), .rd_n_o(b_rd_n), .wr_n_o(b_wr_n)
    );

    // Expected control bundle for cycle k after the acceptance edge
    // (cycle 1 = first SETUP cycle), single isolated transaction.
    function automatic logic [5:0] exp_ctrl(input int k, input int s,
                                            input int p, input int h,
                                            input logic wr);
        int   t;
        logic busy, pulse, rsp;
        t     = s + p + h;
        busy  = (k >= 1) && (k <= t);
        pulse = (k > s) && (k <= s + p);
        rsp   = (k == t + 1);
        return {~busy, ~(pulse & ~wr), ~(pulse & wr), busy & wr, rsp, ~busy};
    endfunction

    // Presents a request on A and returns just after the acceptance edge.
    task automatic start_a(input logic wr, input logic [24:0] addr,
                           input logic [15:0] wd, input bit keep,
                           output bit timed_out);
        int n = 0;
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wd;
        while (!a_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        timed_out = !a_req_ready;
        @(posedge clk);
        #1;
        if (!keep) a_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        vectors++;
        if (a_ctrl !== 6'b111000) begin
            miscompares++;
            $display("FAIL reset_ctrl_a got=%b exp=%b", a_ctrl, 6'b111000);
        end
        vectors++;
        if (b_ctrl !== 6'b111000) begin
            miscompares++;
            $display("FAIL reset_ctrl_b got=%b exp=%b", b_ctrl, 6'b111000);
        end
        vectors++;
        if (a_addr !== 25'h0 || a_data_o !== 16'h0 || a_rsp_rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data_a addr=%h data=%h rdata=%h exp all 0",
                     a_addr, a_data_o, a_rsp_rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_ctrl !== 6'b111001) begin
            miscompares++;
            $display("FAIL reset_release_ready got=%b exp=%b", a_ctrl, 6'b111001);
        end
    endtask

    task automatic test_write();
        bit to;
        start_a(1'b1, 25'h0000010, 16'h1234, 1'b0, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL write_accept got=timeout exp=accepted");
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (a_ctrl !== exp_ctrl(k, 1, 2, 1, 1'b1)) begin
                miscompares++;
                $display("FAIL write_ctrl k=%0d got=%b exp=%b", k, a_ctrl, exp_ctrl(k, 1, 2, 1, 1'b1));
            end
            vectors++;
            if (a_addr !== 25'h0000010 || (k <= 4 && a_data_o !== 16'h1234)) begin
                miscompares++;
                $display("FAIL write_bus k=%0d addr=%h data=%h exp addr=0000010 data=1234",
                         k, a_addr, a_data_o);
            end
        end
    endtask

    task automatic test_read();
        bit to;
        a_model = 16'hBEEF;
        start_a(1'b0, 25'h0000020, 16'hFFFF, 1'b0, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL read_accept got=timeout exp=accepted");
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (a_ctrl !== exp_ctrl(k, 1, 2, 1, 1'b0)) begin
                miscompares++;
                $display("FAIL read_ctrl k=%0d got=%b exp=%b", k, a_ctrl, exp_ctrl(k, 1, 2, 1, 1'b0));
            end
            if (k >= 5) begin
                vectors++;
                if (a_rsp_rdata !== 16'hBEEF) begin
                    miscompares++;
                    $display("FAIL read_rdata k=%0d got=%h exp=BEEF", k, a_rsp_rdata);
                end
            end
        end
        vectors++;
        if (a_addr !== 25'h0000020) begin
            miscompares++;
            $display("FAIL read_addr_retain got=%h exp=0000020", a_addr);
        end
    endtask

    task automatic test_back_to_back();
        bit          to;
        int          m, txn, pulses;
        logic [5:0]  exp;
        logic [15:0] wd [3];
        logic [24:0] ad [3];
        logic [24:0] ad_exp [3];
        wd     = '{16'h1111, 16'h2222, 16'h3333};
        ad     = '{25'h0000100, 25'h0000203, 25'h0000304};
        ad_exp = '{25'h0000100, 25'h0000202, 25'h0000304};
        pulses = 0;
        start_a(1'b1, ad[0], wd[0], 1'b1, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL b2b_accept got=timeout exp=accepted");
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            m   = (k - 1) % 5;
            txn = (k - 1) / 5;
            if (k == 16) exp = 6'b111001;
            else exp = {m == 4, 1'b1, !(m == 1 || m == 2), m != 4, m == 4, m == 4};
            if (a_rsp_valid) pulses++;
            vectors++;
            if (a_ctrl !== exp) begin
                miscompares++;
                $display("FAIL b2b_ctrl k=%0d got=%b exp=%b", k, a_ctrl, exp);
            end
            if (k <= 15 && m != 4) begin
                vectors++;
                if (a_data_o !== wd[txn] || a_addr !== ad_exp[txn]) begin
                    miscompares++;
                    $display("FAIL b2b_bus k=%0d data=%h addr=%h exp data=%h addr=%h",
                             k, a_data_o, a_addr, wd[txn], ad_exp[txn]);
                end
            end
            // Next request's fields change while the bus is busy.
            if (k == 2 || k == 7) begin
                a_req_wdata = wd[txn + 1];
                a_req_addr  = ad[txn + 1];
            end
            if (k == 12) begin
                a_req_valid = 1'b0;
                a_req_wdata = 16'hDEAD;
                a_req_addr  = 25'h1555555;
            end
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL b2b_rsp_count got=%0d exp=3", pulses);
        end
        vectors++;
        if (a_rsp_rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL b2b_rdata_hold got=%h exp=BEEF", a_rsp_rdata);
        end
    endtask

    task automatic test_long_timing();
        int n = 0;
        int low = 0;
        b_model = 16'h5A5A;
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_write = 1'b0;
        b_req_addr  = 25'h0ABCDE1;
        while (!b_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!b_req_ready) begin
            miscompares++;
            $display("FAIL long_accept got=timeout exp=accepted");
        end
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!b_rd_n) low++;
            vectors++;
            if (b_ctrl !== exp_ctrl(k, 3, 5, 2, 1'b0)) begin
                miscompares++;
                $display("FAIL long_ctrl k=%0d got=%b exp=%b", k, b_ctrl, exp_ctrl(k, 3, 5, 2, 1'b0));
            end
            if (k == 11) begin
                vectors++;
                if (b_rsp_rdata !== 16'h5A5A || b_addr !== 25'h0ABCDE0) begin
                    miscompares++;
                    $display("FAIL long_rdata got=%h addr=%h exp=5A5A addr=0ABCDE0",
                             b_rsp_rdata, b_addr);
                end
            end
        end
        vectors++;
        if (low != 5) begin
            miscompares++;
            $display("FAIL long_strobe_len got=%0d exp=5", low);
        end
    endtask

    task automatic test_reset_abort();
        bit to;
        a_model = 16'hC0DE;
        start_a(1'b0, 25'h0000040, 16'h0000, 1'b0, to);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (to || a_ctrl !== exp_ctrl(2, 1, 2, 1, 1'b0)) begin
            miscompares++;
            $display("FAIL abort_prep got=%b exp=%b", a_ctrl, exp_ctrl(2, 1, 2, 1, 1'b0));
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (a_ctrl !== 6'b111000) begin
            miscompares++;
            $display("FAIL abort_async got=%b exp=%b", a_ctrl, 6'b111000);
        end
        vectors++;
        if (a_rsp_rdata !== 16'h0000 || a_addr !== 25'h0) begin
            miscompares++;
            $display("FAIL abort_clear rdata=%h addr=%h exp 0", a_rsp_rdata, a_addr);
        end
        @(negedge clk);
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (a_ctrl !== 6'b111001) begin
                miscompares++;
                $display("FAIL abort_idle k=%0d got=%b exp=%b", k, a_ctrl, 6'b111001);
            end
        end
        start_a(1'b1, 25'h0000050, 16'hABCD, 1'b0, to);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (to || a_ctrl !== exp_ctrl(k, 1, 2, 1, 1'b1)) begin
                miscompares++;
                $display("FAIL abort_next_ctrl k=%0d got=%b exp=%b", k, a_ctrl, exp_ctrl(k, 1, 2, 1, 1'b1));
            end
        end
        vectors++;
        if (a_data_o !== 16'hABCD || a_addr !== 25'h0000050) begin
            miscompares++;
            $display("FAIL abort_next_bus data=%h addr=%h exp data=ABCD addr=0000050",
                     a_data_o, a_addr);
        end
    endtask

    task automatic test_addr_max();
        bit to;
        start_a(1'b1, 25'h1FFFFFF, 16'h0F0F, 1'b0, to);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (to || a_addr !== 25'h1FFFFFE) begin
                miscompares++;
                $display("FAIL addr_max k=%0d got=%h exp=1FFFFFE", k, a_addr);
            end
        end
    endtask

    initial begin
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_model = '0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_model = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_long_timing();
        test_reset_abort();
        test_addr_max();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
